// File: rtl/sync_byte_ram.sv
// sync_byte_ram: single-port synchronous word RAM with byte enables,
// a valid/ready request port and a 2-entry response FIFO.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (memory is not reset)
//   req_valid  request present
//   req_ready  request can be accepted this cycle
//   req_we     1 = write, 0 = read
//   req_addr   byte address
//   req_sel    byte enables, bit i covers data bits 8i+7:8i
//   req_wdata  write data
//   rsp_valid  response present (FIFO non-empty)
//   rsp_ready  consumer accepts the response
//   rsp_rdata  read data; 0 for writes and errors
//   rsp_err    request was out of range or misaligned
module sync_byte_ram #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int ADDR_WIDTH  = 32,
  parameter int ALIGN_CHECK = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_sel,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int unsigned BYTES   = DATA_WIDTH / 8;
  localparam int unsigned OFF     = $clog2(BYTES);
  localparam int unsigned DEPTH   = 2 ** DEPTH_LOG2;
  localparam int unsigned IDX_TOP = DEPTH_LOG2 + OFF;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic                  r_fifo_err  [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;
  logic                  r_active;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_hi_err;
  logic                  w_mis_err;
  logic                  w_err;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_rsp_data;

  // Address decode; shift/mask form keeps this legal for OFF=0 and
  // for ADDR_WIDTH == IDX_TOP (no high bits to test).
  always_comb begin
    w_idx     = DEPTH_LOG2'(req_addr >> OFF);
    w_hi_err  = (req_addr >> IDX_TOP) != '0;
    w_mis_err = (ALIGN_CHECK != 0) && ((req_addr & OFF_MASK) != '0);
    w_err     = w_hi_err || w_mis_err;
  end

  // r_active holds req_ready low until the first edge after reset release.
  // When full, a pop in the same cycle frees a slot (pass-through).
  always_comb begin
    rsp_valid = (r_count != 2'd0);
    req_ready = r_active && ((r_count != 2'd2) || rsp_ready);
    w_push    = req_valid && req_ready;
    w_pop     = rsp_valid && rsp_ready;
    rsp_rdata = rsp_valid ? r_fifo_data[r_rptr] : '0;
    rsp_err   = rsp_valid ? r_fifo_err[r_rptr]  : 1'b0;
  end

  always_comb begin
    w_rsp_data = '0;
    if (!req_we && !w_err) begin
      w_rsp_data = r_mem[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && req_we && !w_err) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (req_sel[i]) begin
          r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_err[i]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wptr] <= w_rsp_data;
        r_fifo_err[r_wptr]  <= w_err;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_byte_ram.sv
// tb_sync_byte_ram: directed scenarios plus randomized traffic for
// sync_byte_ram (defaults: 32-bit data, 1024 words), checked against a
// behavioural model: an array for memory and a queue of expected responses.
module tb_sync_byte_ram;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  sync_byte_ram #(
    .DATA_WIDTH (32),
    .DEPTH_LOG2 (10),
    .ADDR_WIDTH (32),
    .ALIGN_CHECK(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_sel  (req_sel),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model
  typedef struct {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] mem_m [1024];
  rsp_t        exp_q [$];
  logic        active;

  always @(posedge clk or posedge rst) begin
    if (rst) active <= 1'b0;
    else     active <= 1'b1;
  end

  // Mid-cycle monitor: inputs change only just after a rising edge, so the
  // values seen here are what the next edge will act on.
  always @(negedge clk) begin
    rsp_t r;
    logic [9:0] idx;
    if (rst) begin
      exp_q.delete();
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err",   rsp_err,   0);
    end else begin
      check("req_ready", req_ready, active && (exp_q.size() < 2 || rsp_ready));
      check("rsp_valid", rsp_valid, exp_q.size() != 0);
      if (rsp_valid && exp_q.size() != 0) begin
        check("rsp_err",   rsp_err,   exp_q[0].err);
        check("rsp_rdata", rsp_rdata, exp_q[0].data);
        if (rsp_ready) void'(exp_q.pop_front());
      end
      if (req_valid && req_ready) begin
        idx    = req_addr[11:2];
        r.err  = (req_addr >= 32'h1000) || (req_addr[1:0] != 2'b00);
        r.data = 32'h0;
        if (req_we) begin
          if (!r.err)
            for (int b = 0; b < 4; b++)
              if (req_sel[b]) mem_m[idx][8*b +: 8] = req_wdata[8*b +: 8];
        end else if (!r.err) begin
          r.data = mem_m[idx];
        end
        exp_q.push_back(r);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 just after acceptance.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd);
    logic got;
    got       = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_sel   = sel;
    req_wdata = wd;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!got) check("req_accept_timeout", 0, 1);
  endtask

  task automatic idle(input int cycles);
    req_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic err, input logic [31:0] data);
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_err"},   rsp_err,   err);
    check({tag, "_rdata"}, rsp_rdata, data);
  endtask

  int unsigned n_acc;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_sel   = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    #2;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_req_ready", req_ready, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("ready_before_first_edge", req_ready, 0);
    @(posedge clk);
    #1 check("ready_after_first_edge", req_ready, 1);
    rsp_ready = 1'b1;

    // Known contents for words 0..15, written back to back
    for (int i = 0; i < 16; i++) do_req(1'b1, 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i));
    idle(2);

    // Full write then read-back, read one cycle after the write
    do_req(1'b1, 32'h10, 4'hF, 32'h1122_3344);
    do_req(1'b0, 32'h10, 4'h0, 32'h0);
    check_head("rd_full_write", 1'b0, 32'h1122_3344);
    idle(2);

    // Partial byte write
    do_req(1'b1, 32'h10, 4'b0101, 32'hAABB_CCDD);
    do_req(1'b0, 32'h10, 4'hF, 32'h0);
    check_head("rd_partial_write", 1'b0, 32'h11BB_33DD);
    idle(1);

    // Write with no byte enables leaves the word alone
    do_req(1'b1, 32'h14, 4'h0, 32'hDEAD_BEEF);
    check_head("wr_sel0_rsp", 1'b0, 32'h0);
    do_req(1'b0, 32'h14, 4'h0, 32'h0);
    check_head("rd_after_sel0", 1'b0, 32'hA000_0005);

    // Error cases
    do_req(1'b0, 32'h1002, 4'hF, 32'h0);
    check_head("rd_1002", 1'b1, 32'h0);
    do_req(1'b0, 32'h1000, 4'hF, 32'h0);
    check_head("rd_1000", 1'b1, 32'h0);
    do_req(1'b0, 32'h12, 4'hF, 32'h0);
    check_head("rd_misaligned", 1'b1, 32'h0);
    do_req(1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF);
    check_head("wr_1000_rsp", 1'b1, 32'h0);
    do_req(1'b0, 32'h0, 4'hF, 32'h0);
    check_head("rd_word0_unchanged", 1'b0, 32'hA000_0000);
    do_req(1'b1, 32'h13, 4'hF, 32'hFFFF_FFFF);
    check_head("wr_misaligned_rsp", 1'b1, 32'h0);
    do_req(1'b0, 32'h10, 4'hF, 32'h0);
    check_head("rd_word4_unchanged", 1'b0, 32'h11BB_33DD);
    idle(2);

    // Backpressure: two accepted, third waits, then passes through on pop
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_sel = 4'hF; req_addr = 32'h0;
    @(posedge clk); #1 req_addr = 32'h4;
    @(posedge clk); #1 req_addr = 32'h8;
    @(negedge clk);
    check("full_req_ready", req_ready, 0);
    @(posedge clk);
    #1 check_head("hold_head", 1'b0, 32'hA000_0000);
    rsp_ready = 1'b1;
    #1 check("pass_through_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check_head("second_head", 1'b0, 32'hA000_0001);
    idle(4);

    // Asynchronous reset with two responses queued
    rsp_ready = 1'b0;
    do_req(1'b0, 32'h10, 4'hF, 32'h0);
    do_req(1'b0, 32'h0, 4'hF, 32'h0);
    req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", rsp_valid, 0);
    check("async_rst_ready", req_ready, 0);
    check("async_rst_rdata", rsp_rdata, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("rst_release_ready", req_ready, 0);
    @(posedge clk);
    #1 check("rst_first_edge_ready", req_ready, 1);
    rsp_ready = 1'b1;
    do_req(1'b0, 32'h10, 4'hF, 32'h0);
    check_head("mem_survives_reset", 1'b0, 32'h11BB_33DD);
    idle(2);

    // Randomized traffic
    n_acc = 0;
    for (int cyc = 0; cyc < 3000 && n_acc < 100; cyc++) begin
      logic [31:0] a;
      int unsigned r;
      a = 32'($urandom_range(0, 15)) << 2;
      r = $urandom_range(0, 9);
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = a | (32'h1000 << $urandom_range(0, 19));
      req_valid = ($urandom % 5) != 0;
      req_we    = $urandom % 2;
      req_addr  = a;
      req_sel   = 4'($urandom);
      req_wdata = $urandom;
      rsp_ready = ($urandom % 3) != 0;
      @(negedge clk);
      if (req_valid && req_ready) n_acc++;
      @(posedge clk);
      #1;
    end
    check("random_accepted", n_acc, 100);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_rsp_valid", rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_byte_ram.md
SYNC_BYTE_RAM -- requirements
Module: sync_byte_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, log2 of the number of words.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, byte-address width; it SHALL be at least DEPTH_LOG2+OFF, where OFF=log2(DATA_WIDTH/8).
REQ-004 SHALL have parameter ALIGN_CHECK, default 1; 1 flags misaligned addresses as errors, 0 ignores the offset bits.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request can be accepted this cycle.
REQ-009 req_we  input  1  1=write, 0=read.
REQ-010 req_addr  input  ADDR_WIDTH  byte address.
REQ-011 req_sel  input  DATA_WIDTH/8  byte enables; bit i covers data bits 8i+7:8i.
REQ-012 req_wdata  input  DATA_WIDTH  write data.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-016 rsp_err  output  1  request was out of range or misaligned.

Function
REQ-017 A request SHALL be accepted exactly when req_valid and req_ready are both 1 at a rising edge.
REQ-018 Word index SHALL be req_addr[DEPTH_LOG2+OFF-1:OFF].
REQ-019 A request SHALL be an error when any req_addr bit at or above DEPTH_LOG2+OFF is 1, or when ALIGN_CHECK=1 and req_addr[OFF-1:0] is nonzero.
REQ-020 An accepted non-error write SHALL update only the bytes whose req_sel bit is 1, at the acceptance edge.
REQ-021 An accepted write with req_sel all zero SHALL leave memory unchanged and still produce a response.
REQ-022 An error write SHALL leave memory unchanged.
REQ-023 Read data SHALL be captured from the array at the acceptance edge (1-cycle read latency); it is independent of req_sel.
REQ-024 A read accepted in the cycle after a write to the same word SHALL return the updated data.
REQ-025 Every accepted request SHALL produce exactly one response, in acceptance order.
REQ-026 The earliest response SHALL appear with rsp_valid=1 in the cycle after acceptance.
REQ-027 Responses SHALL be held in a 2-entry FIFO; rsp_valid=1 while the FIFO is non-empty.
REQ-028 rsp_rdata and rsp_err SHALL show the head entry and stay stable while rsp_valid=1 and rsp_ready=0.
REQ-029 A response SHALL be popped when rsp_valid and rsp_ready are both 1 at a rising edge.
REQ-030 req_ready SHALL be 1 when FIFO occupancy is below 2, and SHALL also be 1 when occupancy is 2 and a pop occurs in the same cycle (pass-through, combinational on rsp_ready).
REQ-031 Simultaneous push and pop SHALL leave occupancy unchanged; FIFO pointers SHALL wrap modulo 2.
REQ-032 Error responses SHALL have rsp_err=1 and rsp_rdata=0.
REQ-033 Non-error write responses SHALL have rsp_err=0 and rsp_rdata=0.
REQ-034 Back-to-back requests SHALL be sustained at one per cycle while rsp_ready is held at 1.

Reset
REQ-035 While rst=1, req_ready, rsp_valid, rsp_rdata and rsp_err SHALL be 0 and occupancy SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL discard all queued responses immediately, without waiting for a clock edge.
REQ-037 Memory contents SHALL NOT be reset.
REQ-038 req_ready SHALL return to 1 at the first rising edge after rst deasserts.

Verification (defaults, DATA_WIDTH=32)
REQ-039 Scenario: write 0x11223344 to address 0x10 with sel=4'b1111, then read 0x10 -> read response rdata=0x11223344, err=0, appearing 1 cycle after acceptance.
REQ-040 Scenario: write 0xAABBCCDD to address 0x10 with sel=4'b0101 over prior 0x11223344, then read -> rdata=0x11BB33DD.
REQ-041 Scenario: read address 0x1002 -> err=1, rdata=0 (misaligned); read address 0x1000 -> err=1 (out of range); a write to 0x1000 alters no word.
REQ-042 Scenario: rsp_ready=0 with 3 requests offered -> 2 accepted, req_ready=0; raise rsp_ready -> third request accepted in the same cycle as the first pop; responses arrive in order.
REQ-043 Scenario: assert rst while 2 responses are queued -> rsp_valid=0 with no clock edge; memory still holds 0x11BB33DD at 0x10 after reset.
REQ-044 Scenario: 100 random back-to-back requests with random rsp_ready -> responses match a reference model in order with no loss or duplication.
